// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, oversampling ratio
// and the baud divider calculation.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } uart_rx_state_t;

    localparam int UART_OVERSAMPLE = 16;

    // Rounded clk_freq / (baud * 16), never below 1.
    function automatic int uart_div(input longint clk_freq,
                                    input longint baud);
        longint den;
        longint q;
        den = baud * UART_OVERSAMPLE;
        q = (clk_freq + den / 2) / den;
        return (q < 1) ? 1 : int'(q);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick divider: one-cycle tick every DIV clocks,
// phase restarted while restart is high.
module uart_baud_tick #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic res_n,
    input  logic restart,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!res_n || restart) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == CW'(DIV - 1)) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + 1'b1;
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 debug UART receiver, 16x oversampled, with a single-entry
// valid/ready holding register.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 100000000,
    parameter int BAUD      = 921600,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 res_n,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int DIV = uart_div(CLK_FREQ, BAUD);
    localparam int SW  = $clog2(UART_OVERSAMPLE);
    localparam int BW  = $clog2(DATA_BITS + 1);
    localparam logic [SW-1:0] MID = SW'(UART_OVERSAMPLE / 2 - 1);

    uart_rx_state_t state_q, state_d;

    logic                 rx_m, rx_s;
    logic                 tick, restart, sample;
    logic [SW-1:0]        scnt;
    logic [BW-1:0]        bcnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 shift, deliver, ferr;

    assign restart = (state_q == S_IDLE);
    assign sample  = tick && (scnt == MID);
    assign busy    = (state_q != S_IDLE);

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk     (clk),
        .res_n   (res_n),
        .restart (restart),
        .tick    (tick)
    );

    always_ff @(posedge clk) begin
        if (!res_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift   = 1'b0;
        deliver = 1'b0;
        ferr    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!rx_s) state_d = S_START;
            end
            S_START: begin
                if (sample) state_d = rx_s ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (sample) begin
                    shift = 1'b1;
                    if (bcnt == BW'(DATA_BITS - 1)) state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (sample) begin
                    if (rx_s) begin
                        deliver = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr    = 1'b1;
                        state_d = S_WAIT_HIGH;
                    end
                end
            end
            S_WAIT_HIGH: begin
                if (rx_s) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Sample counter free-runs mod 16 after the start edge, so
    // each data/stop sample lands 16 ticks after the previous one.
    always_ff @(posedge clk) begin
        if (!res_n) begin
            rx_m      <= 1'b1;
            rx_s      <= 1'b1;
            scnt      <= '0;
            bcnt      <= '0;
            shreg     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            rx_m <= rx_in;
            rx_s <= rx_m;
            if (state_q == S_IDLE) begin
                scnt <= '0;
            end else if (tick) begin
                scnt <= scnt + 1'b1;
            end
            if (state_q == S_START) begin
                bcnt <= '0;
            end else if (shift) begin
                bcnt <= bcnt + 1'b1;
            end
            if (shift) shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            frame_err <= ferr;
            overrun   <= deliver && valid && !ready;
            if (deliver && (!valid || ready)) begin
                data  <= shreg;
                valid <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at DIV=4 (64 clk per bit).
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       res_n;
    logic       rx_in;
    logic       ready;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] rx_q[$];
    int valid_cyc, ferr_cnt, ovr_cnt, both_cnt, busy_rise;
    logic busy_prev = 1'b0;

    uart_rx #(
        .CLK_FREQ  (1600000),
        .BAUD      (25000),
        .DATA_BITS (8)
    ) dut (
        .clk       (clk),
        .res_n     (res_n),
        .rx_in     (rx_in),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (res_n === 1'b1) begin
            if (valid && ready) rx_q.push_back(data);
            if (valid) valid_cyc++;
            if (frame_err) ferr_cnt++;
            if (overrun) ovr_cnt++;
            if (frame_err && overrun) both_cnt++;
            if (busy && !busy_prev) busy_rise++;
        end
        busy_prev = busy;
    end

    task automatic clear_mon();
        rx_q.delete();
        valid_cyc = 0;
        ferr_cnt  = 0;
        ovr_cnt   = 0;
        both_cnt  = 0;
        busy_rise = 0;
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send_bit(input logic b);
        rx_in = b;
        wait_clk(64);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
    endtask

    task automatic test_reset();
        res_n = 1'b0;
        rx_in = 1'b1;
        ready = 1'b1;
        wait_clk(3);
        n_cmp++;
        if ({data, valid, frame_err, overrun, busy} !== 12'h000) begin
            n_err++;
            $display("FAIL rst_outputs got %h want 000",
                     {data, valid, frame_err, overrun, busy});
        end
        res_n = 1'b1;
        wait_clk(10);
        n_cmp++;
        if (busy !== 1'b0 || valid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_idle got busy=%b valid=%b want 0 0",
                     busy, valid);
        end
    endtask

    task automatic test_frame_55();
        ready = 1'b1;
        clear_mon();
        send_frame(8'h55, 1'b1);
        wait_clk(16);
        n_cmp++;
        if (rx_q.size() !== 1) begin
            n_err++;
            $display("FAIL f55_count got %0d want 1", rx_q.size());
        end
        n_cmp++;
        if (rx_q.size() > 0 && rx_q[0] !== 8'h55) begin
            n_err++;
            $display("FAIL f55_data got %h want 55", rx_q[0]);
        end
        n_cmp++;
        if (valid_cyc !== 1) begin
            n_err++;
            $display("FAIL f55_valid_len got %0d want 1", valid_cyc);
        end
        n_cmp++;
        if (ferr_cnt !== 0 || busy !== 1'b0 || busy_rise !== 1) begin
            n_err++;
            $display("FAIL f55_status got ferr=%0d busy=%b rises=%0d want 0 0 1",
                     ferr_cnt, busy, busy_rise);
        end
    endtask

    task automatic test_glitch();
        clear_mon();
        rx_in = 1'b0;
        wait_clk(20);
        rx_in = 1'b1;
        wait_clk(100);
        n_cmp++;
        if (busy_rise !== 1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL glitch_busy got rises=%0d busy=%b want 1 0",
                     busy_rise, busy);
        end
        n_cmp++;
        if (valid_cyc !== 0 || ferr_cnt !== 0) begin
            n_err++;
            $display("FAIL glitch_quiet got valid=%0d ferr=%0d want 0 0",
                     valid_cyc, ferr_cnt);
        end
    endtask

    task automatic test_frame_err();
        ready = 1'b1;
        clear_mon();
        send_frame(8'hA3, 1'b0);
        wait_clk(136);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL ferr_busy_low got %b want 1", busy);
        end
        n_cmp++;
        if (ferr_cnt !== 1) begin
            n_err++;
            $display("FAIL ferr_pulse got %0d want 1", ferr_cnt);
        end
        n_cmp++;
        if (valid_cyc !== 0) begin
            n_err++;
            $display("FAIL ferr_no_valid got %0d want 0", valid_cyc);
        end
        rx_in = 1'b1;
        wait_clk(8);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL ferr_busy_release got %b want 0", busy);
        end
        wait_clk(64);
        clear_mon();
        send_frame(8'h41, 1'b1);
        wait_clk(16);
        n_cmp++;
        if (rx_q.size() !== 1 || ferr_cnt !== 0) begin
            n_err++;
            $display("FAIL ferr_next_count got %0d ferr=%0d want 1 0",
                     rx_q.size(), ferr_cnt);
        end
        n_cmp++;
        if (rx_q.size() > 0 && rx_q[0] !== 8'h41) begin
            n_err++;
            $display("FAIL ferr_next_data got %h want 41", rx_q[0]);
        end
    endtask

    task automatic test_overrun();
        ready = 1'b0;
        clear_mon();
        send_frame(8'h12, 1'b1);
        send_frame(8'h34, 1'b1);
        wait_clk(16);
        n_cmp++;
        if (valid !== 1'b1 || data !== 8'h12) begin
            n_err++;
            $display("FAIL ovr_hold got valid=%b data=%h want 1 12",
                     valid, data);
        end
        n_cmp++;
        if (ovr_cnt !== 1) begin
            n_err++;
            $display("FAIL ovr_pulse got %0d want 1", ovr_cnt);
        end
        n_cmp++;
        if (both_cnt !== 0 || ferr_cnt !== 0) begin
            n_err++;
            $display("FAIL ovr_excl got both=%0d ferr=%0d want 0 0",
                     both_cnt, ferr_cnt);
        end
        ready = 1'b1;
        wait_clk(4);
        n_cmp++;
        if (rx_q.size() !== 1 || valid !== 1'b0) begin
            n_err++;
            $display("FAIL ovr_drain got count=%0d valid=%b want 1 0",
                     rx_q.size(), valid);
        end
        n_cmp++;
        if (rx_q.size() > 0 && rx_q[0] !== 8'h12) begin
            n_err++;
            $display("FAIL ovr_drain_data got %h want 12", rx_q[0]);
        end
    endtask

    task automatic test_back_to_back();
        ready = 1'b1;
        clear_mon();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        wait_clk(16);
        n_cmp++;
        if (rx_q.size() !== 2 || valid_cyc !== 2) begin
            n_err++;
            $display("FAIL b2b_count got %0d beats=%0d want 2 2",
                     rx_q.size(), valid_cyc);
        end
        n_cmp++;
        if (rx_q.size() == 2 && (rx_q[0] !== 8'h00 || rx_q[1] !== 8'hFF)) begin
            n_err++;
            $display("FAIL b2b_data got %h %h want 00 ff", rx_q[0], rx_q[1]);
        end
    endtask

    task automatic test_mid_reset();
        logic [7:0] b;
        b = 8'h99;
        ready = 1'b0;
        clear_mon();
        send_frame(8'h5A, 1'b1);
        wait_clk(16);
        n_cmp++;
        if (valid !== 1'b1 || data !== 8'h5A) begin
            n_err++;
            $display("FAIL mrst_held got valid=%b data=%h want 1 5a",
                     valid, data);
        end
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(b[i]);
        rx_in = b[3];
        wait_clk(32);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL mrst_busy_before got %b want 1", busy);
        end
        res_n = 1'b0;
        wait_clk(1);
        res_n = 1'b1;
        rx_in = 1'b1;
        n_cmp++;
        if ({data, valid, frame_err, overrun, busy} !== 12'h000) begin
            n_err++;
            $display("FAIL mrst_outputs got %h want 000",
                     {data, valid, frame_err, overrun, busy});
        end
        wait_clk(200);
        ready = 1'b1;
        wait_clk(4);
        n_cmp++;
        if (rx_q.size() !== 0) begin
            n_err++;
            $display("FAIL mrst_discard got %0d want 0", rx_q.size());
        end
        clear_mon();
        send_frame(8'hC3, 1'b1);
        wait_clk(16);
        n_cmp++;
        if (rx_q.size() !== 1) begin
            n_err++;
            $display("FAIL mrst_next_count got %0d want 1", rx_q.size());
        end
        n_cmp++;
        if (rx_q.size() > 0 && rx_q[0] !== 8'hC3) begin
            n_err++;
            $display("FAIL mrst_next_data got %h want c3", rx_q[0]);
        end
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_frame_55();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_back_to_back();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the debug UART; the receive-side counterpart of the existing `uart`/`uart_tx`/`uart_clk` transmit path. It samples an asynchronous 8N1 line at 16× oversampling, validates start and stop bits, and presents each byte on a valid/ready handshake through a single-entry holding register. It sits beside `uart` at top level and lets host commands reach the controller's debugger path.

## Interface
- `CLK_FREQ`, 100000000: system clock frequency in Hz.
- `BAUD`, 921600: line rate in bit/s.
- `DATA_BITS`, 8: data bits per frame; no parity; one stop bit.
- `clk`  in  1  system clock; only clock in the block.
- `res_n`  in  1  reset; synchronous, active-low.
- `rx_in`  in  1  asynchronous serial line; idles high.
- `data`  out  DATA_BITS  received byte, LSB = first bit on the line.
- `valid`  out  1  `data` holds an unconsumed byte.
- `ready`  in  1  consumer accepts `data` on a cycle where `valid && ready`.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun`  out  1  one-cycle pulse: a byte completed while the holding register was full; the new byte is dropped.
- `busy`  out  1  high while a frame is being received (FSM not IDLE).

## Operation
- Input synchronizer: two flops on `rx_in`, both reset to 1. The output is `rx_s`.
- Tick generator: `DIV = round(CLK_FREQ / (BAUD*16))`, minimum 1. It emits a one-cycle `tick` every DIV clocks. The counter restarts when the FSM leaves IDLE, so ticks are phase-aligned to the start edge.
- Sample counter: 4 bits, counts ticks within a bit. The bit sample point is tick 7, the 8th tick, at mid-bit.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: `rx_s == 0` → START, with the tick and sample counters cleared.
  - START: at the sample point, if `rx_s == 0` → DATA with the bit counter at 0. Otherwise → IDLE (glitch rejected, nothing reported).
  - DATA: every 16 ticks after the start sample, shift `rx_s` in at MSB and shift right. After DATA_BITS samples → STOP.
  - STOP: at the sample point:
    - `rx_s == 1`: the byte is delivered and the FSM → IDLE immediately. This allows back-to-back frames.
    - `rx_s == 0`: pulse `frame_err`, discard the byte, → WAIT_HIGH.
  - WAIT_HIGH: stay until `rx_s == 1`, then → IDLE. This prevents a break or stuck-low line from creating phantom frames.
- Delivery into the holding register:
  - Empty, or `valid && ready` in the same cycle: load `data`, set `valid`.
  - Full and not being consumed: keep the old byte, pulse `overrun`.
- `valid` clears on `valid && ready` unless a new byte loads in the same cycle.
- `data` is stable while `valid` is high.

## Timing
- Reset values: `data` = 0, `valid` = 0, `frame_err` = 0, `overrun` = 0, `busy` = 0. The FSM goes to IDLE and all counters clear.
- Reset mid-frame discards the partial byte and any held byte.
- Latency:
  - The falling edge on `rx_in` reaches `rx_s` after 2 clk.
  - `valid` rises the cycle after the stop-bit sample, which is (16·(DATA_BITS+1)+8)·DIV clk after `rx_s` falls, ±1 clk.
- `frame_err` and `overrun` are registered and high for exactly 1 clk. They never assert in the same cycle.
- `busy` rises 1 clk after `rx_s` falls. It drops in the cycle after the stop sample, or on exit from WAIT_HIGH.
- Baud tolerance: framing is correct for a transmitter clock error of up to ±3% at DIV ≥ 4.
- `ready` may be held high permanently. The block never stalls the line.

## Structure
- Shared package `uart_pkg`:
  - FSM state enum `uart_rx_state_t`.
  - Constant `UART_OVERSAMPLE = 16`.
  - Function `uart_div(clk_freq, baud)` with the rounding and minimum-1 rule.
  - `uart_clk` is to be migrated to the same package.
- Sub-module `uart_baud_tick`: parameterised divider with a synchronous `restart` input and a `tick` output. The FSM, synchronizer, shift register and holding register stay in `uart_rx`.

## Test plan
All scenarios use `CLK_FREQ`=1600000 and `BAUD`=25000, giving DIV=4 and 64 clk per bit.
- Frame 0x55, `ready`=1 → `valid` high for 1 clk with `data`=0x55, no `frame_err`, `busy` low afterwards.
- `rx_in` low for 20 clk then high → `busy` pulses and returns low, no `valid`, no `frame_err`.
- Frame 0xA3 with stop bit low, line held low 200 clk, then frame 0x41 → one `frame_err` pulse, no `valid` for 0xA3, `busy` high until the line rises, then `data`=0x41 `valid`.
- `ready`=0, frames 0x12 then 0x34 → `data`=0x12 held, `overrun` pulse at the second stop sample. Then `ready`=1 → 0x12 consumed once and `valid` drops.
- Back-to-back 0x00, 0xFF with no idle gap, `ready`=1 → two `valid` beats: 0x00 then 0xFF.
- `res_n` low for 1 clk during data bit 3 → all outputs 0 next cycle. The next frame 0xC3 is received correctly.
